// File: rtl/screen_sequencer.sv
// Screen sequencer: maps the OLED raster index to x/y, muxes the active screen's colour,
// and steps TITLE/SCREEN1/SCREEN2/PLAY on frame boundaries. Optional idle fallback: SCREEN_IDLE_TIMEOUT_EN.
module screen_sequencer #(
    parameter int IDLE_FRAMES = 1800
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [12:0] pixel_index,
    input  logic        frame_begin,
    input  logic        btn_next,
    input  logic        btn_back,
    input  logic [15:0] scr0_data,
    input  logic [15:0] scr1_data,
    input  logic [15:0] scr2_data,
    input  logic [15:0] scr3_data,
    output logic [6:0]  x,
    output logic [5:0]  y,
    output logic [1:0]  screen_sel,
    output logic [15:0] oled_data,
    output logic        screen_changed
);

    typedef enum logic [1:0] {
        S_TITLE   = 2'd0,
        S_SCREEN1 = 2'd1,
        S_SCREEN2 = 2'd2,
        S_PLAY    = 2'd3
    } state_t;

    function automatic state_t next_of(input state_t s);
        case (s)
            S_TITLE:   next_of = S_SCREEN1;
            S_SCREEN1: next_of = S_SCREEN2;
            default:   next_of = S_PLAY;
        endcase
    endfunction

    function automatic state_t back_of(input state_t s);
        case (s)
            S_SCREEN2: back_of = S_SCREEN1;
            default:   back_of = S_TITLE;
        endcase
    endfunction

    state_t state_q, state_d;
    state_t target_q, target_d;
    logic   pending_q, pending_d;
    logic   changed_q, changed_d;

    logic   press_next, press_back, commit, idle_expired;

    assign press_next = btn_next & ~btn_back;
    assign press_back = btn_back & ~btn_next;
    assign commit     = frame_begin & pending_q;

`ifdef SCREEN_IDLE_TIMEOUT_EN
    localparam logic [10:0] IDLE_LIMIT = 11'(IDLE_FRAMES);

    logic [10:0] idle_cnt_q, idle_cnt_d;
    logic        in_menu;

    assign in_menu      = (state_q == S_SCREEN1) || (state_q == S_SCREEN2);
    assign idle_expired = in_menu && !pending_q && !(btn_next || btn_back)
                          && (idle_cnt_q == IDLE_LIMIT);

    always_comb begin
        idle_cnt_d = idle_cnt_q;
        if (!in_menu || commit || btn_next || btn_back || idle_expired) begin
            idle_cnt_d = '0;
        end else if (frame_begin && !pending_q) begin
            idle_cnt_d = idle_cnt_q + 11'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idle_cnt_q <= '0;
        end else begin
            idle_cnt_q <= idle_cnt_d;
        end
    end
`else
    logic unused_idle;
    assign unused_idle  = IDLE_FRAMES[0];
    assign idle_expired = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_TITLE;
            target_q  <= S_TITLE;
            pending_q <= 1'b0;
            changed_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            target_q  <= target_d;
            pending_q <= pending_d;
            changed_q <= changed_d;
        end
    end

    // Only one target may be pending; it lands on the cycle after frame_begin so a frame never switches mid-scan.
    always_comb begin
        state_d   = state_q;
        target_d  = target_q;
        pending_d = pending_q;
        changed_d = 1'b0;
        if (commit) begin
            state_d   = target_q;
            pending_d = 1'b0;
            changed_d = 1'b1;
        end else if (!pending_q) begin
            if (press_next && (state_q != S_PLAY)) begin
                pending_d = 1'b1;
                target_d  = next_of(state_q);
            end else if (press_back && (state_q != S_TITLE)) begin
                pending_d = 1'b1;
                target_d  = back_of(state_q);
            end else if (idle_expired) begin
                pending_d = 1'b1;
                target_d  = S_TITLE;
            end
        end
    end

    always_comb begin
        screen_sel     = state_q;
        screen_changed = changed_q;
    end

    logic        pix_valid;
    logic [6:0]  x_q;
    logic [5:0]  y_q;
    logic        valid_q;
    state_t      sel_px_q;
    logic [15:0] oled_q;
    logic [15:0] scr_mux;

    // Indices 6144..8191 have bits 12 and 11 both set.
    assign pix_valid = ~(pixel_index[12] & pixel_index[11]);

    always_comb begin
        case (sel_px_q)
            S_TITLE:   scr_mux = scr0_data;
            S_SCREEN1: scr_mux = scr1_data;
            S_SCREEN2: scr_mux = scr2_data;
            default:   scr_mux = scr3_data;
        endcase
    end

    // The select is captured with x/y so colour and coordinate stay paired through the pipe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x_q      <= '0;
            y_q      <= '0;
            valid_q  <= 1'b0;
            sel_px_q <= S_TITLE;
            oled_q   <= '0;
        end else begin
            if (pix_valid) begin
                x_q <= 7'(pixel_index % 13'd96);
                y_q <= 6'(pixel_index / 13'd96);
            end else begin
                x_q <= '0;
                y_q <= '0;
            end
            valid_q  <= pix_valid;
            sel_px_q <= state_q;
            oled_q   <= valid_q ? scr_mux : 16'h0000;
        end
    end

    assign x         = x_q;
    assign y         = y_q;
    assign oled_data = oled_q;

endmodule

// File: doc/screen_sequencer.md
SCREEN_SEQUENCER -- requirements
Module: screen_sequencer

Interface
REQ-001: Parameter IDLE_FRAMES, default 1800, number of frames without a button press before falling back to TITLE (30 s at 60 fps).
REQ-002: Clock and reset: one clock; reset is asynchronous and active-low (ports clk and reset_n).
REQ-003: clk  input  1  system clock; all state changes on its rising edge.
REQ-004: reset_n  input  1  asynchronous active-low reset.
REQ-005: pixel_index  input  13  raster index from OLED driver, valid range 0..6143 (96x64).
REQ-006: frame_begin  input  1  one-cycle pulse at the start of each OLED frame.
REQ-007: btn_next  input  1  one-cycle debounced pulse, advance screen.
REQ-008: btn_back  input  1  one-cycle debounced pulse, previous screen.
REQ-009: scr0_data..scr3_data  input  16 each  RGB565 colour from the four screen renderers, combinational in x/y.
REQ-010: x  output  7  column 0..95 fed to all renderers.
REQ-011: y  output  6  row 0..63 fed to all renderers.
REQ-012: screen_sel  output  2  active screen: 0 TITLE, 1 SCREEN1, 2 SCREEN2 (controls), 3 PLAY.
REQ-013: oled_data  output  16  colour returned to OLED driver.
REQ-014: screen_changed  output  1  one-cycle pulse when screen_sel updates.

Function
REQ-015: x = pixel_index mod 96, y = pixel_index / 96, registered: 1-cycle latency from pixel_index.
REQ-016: pixel_index >= 6144: x=0, y=0, and the corresponding oled_data SHALL be 0x0000.
REQ-017: oled_data = scr[screen_sel]_data registered one cycle after x/y: 2-cycle total latency from pixel_index.
REQ-018: FSM states TITLE, SCREEN1, SCREEN2, PLAY; btn_next: TITLE->SCREEN1->SCREEN2->PLAY; in PLAY ignored.
REQ-019: btn_back: SCREEN2->SCREEN1, SCREEN1->TITLE, PLAY->TITLE; in TITLE ignored.
REQ-020: A press sets a single pending target; presses while a target is pending are ignored.
REQ-021: btn_next and btn_back asserted in the same cycle: both ignored.
REQ-022: Pending target commits to screen_sel on the cycle after frame_begin; screen_changed pulses that same cycle; pending clears.
REQ-023: Press coinciding with frame_begin: becomes pending, commits at the following frame_begin (no mid-frame switch ever).
REQ-024: Ignored presses (REQ-018/019/021) create no pending target and no screen_changed pulse.

Reset
REQ-025: reset_n low: screen_sel=0 (TITLE), x=0, y=0, oled_data=0x0000, screen_changed=0, pending cleared, idle counter=0.
REQ-026: Reset asserted mid-frame or with a pending target: pending discarded; after release first commit needs a new press plus frame_begin.

Configuration
REQ-027: Macro SCREEN_IDLE_TIMEOUT_EN defined: idle counter (11 bits) increments on frame_begin while in SCREEN1/SCREEN2 with no pending target; cleared by any btn pulse, by any commit, and held 0 in TITLE/PLAY.
REQ-028: With SCREEN_IDLE_TIMEOUT_EN, counter reaching IDLE_FRAMES sets pending target TITLE, committed per REQ-022, counter cleared.
REQ-029: Without SCREEN_IDLE_TIMEOUT_EN: no counter logic; screens change only on buttons.

Verification
REQ-030: pixel_index=0,95,96,6143 -> (x,y)=(0,0),(95,0),(0,1),(95,63) one cycle later; 6200 -> (0,0), oled_data 0x0000 two cycles later.
REQ-031: TITLE, scr1_data=0x07E0, btn_next at cycle 10, frame_begin at cycle 50 -> screen_sel=1 and screen_changed=1 at cycle 51 only; oled_data=0x07E0 from cycle 53 onward.
REQ-032: SCREEN1, btn_next then btn_next again before frame_begin -> only SCREEN2 after frame_begin; btn_next+btn_back same cycle -> no change.
REQ-033: PLAY, btn_next -> no pending, no pulse; btn_back + frame_begin -> TITLE.
REQ-034: SCREEN_IDLE_TIMEOUT_EN, IDLE_FRAMES=4, SCREEN2, 4 frame_begin pulses no press -> TITLE after 5th frame_begin; press at 3rd frame -> count restarts.
REQ-035: Pending target set, reset_n low 3 cycles mid-frame -> TITLE, outputs 0; subsequent frame_begin without press -> no change.
